// File: rtl/prescaled_counter.sv
// Up/down modulo counter stepped by an internal clock-enable prescaler (no derived clocks).
// Define PRESCALED_COUNTER_OVF_EN to add the sticky ovf flag with its ovf_clr input.
module prescaled_counter #(
    parameter int WIDTH    = 8,
    parameter int DIV      = 50_000_000,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
`ifdef PRESCALED_COUNTER_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]    divcnt;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;

    assign step         = en && (divcnt == DIV_LAST);
    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // Compare before stepping, so an all-ones max_val never needs a carry bit.
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (up) begin
            if (count >= max_val) begin
                boundary   = 1'b1;
                next_count = SATURATE ? max_val : '0;
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count > max_val) begin
                next_count = max_val;
            end else if (count == '0) begin
                boundary   = 1'b1;
                next_count = SATURATE ? '0 : max_val;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            divcnt <= '0;
            tick   <= 1'b0;
            tc     <= 1'b0;
        end else if (load) begin
            count  <= load_clamped;
            divcnt <= '0;
            tick   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
            if (step) begin
                divcnt <= '0;
                count  <= next_count;
                tick   <= 1'b1;
                tc     <= boundary;
            end else if (en) begin
                divcnt <= divcnt + DW'(1);
            end
        end
    end

`ifdef PRESCALED_COUNTER_OVF_EN
    // A boundary step outranks ovf_clr, so a wrap is never lost to a concurrent clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (step && !load && boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench: wrap and saturate instances share stimulus and are compared
// every cycle against a phase-counting arithmetic model.
module tb_prescaled_counter;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst, en, up, load;
    logic [WIDTH-1:0] load_val, max_val;
    logic [WIDTH-1:0] count_w, count_s;
    logic             tick_w, tick_s, tc_w, tc_s;
`ifdef PRESCALED_COUNTER_OVF_EN
    logic             ovf_clr, ovf_w, ovf_s;
`endif

    int passed = 0;
    int total  = 0;

    // Model state, index 0 = wrap instance, 1 = saturate instance.
    int m_cnt [2];
    int m_ph  [2];
    bit m_tick[2];
    bit m_tc  [2];
    bit m_ovf [2];

    always #5 clk = ~clk;

    prescaled_counter #(.WIDTH(WIDTH), .DIV(DIV), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
`ifdef PRESCALED_COUNTER_OVF_EN
        .ovf_clr(ovf_clr), .ovf(ovf_w),
`endif
        .count(count_w), .tick(tick_w), .tc(tc_w)
    );

    prescaled_counter #(.WIDTH(WIDTH), .DIV(DIV), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
`ifdef PRESCALED_COUNTER_OVF_EN
        .ovf_clr(ovf_clr), .ovf(ovf_s),
`endif
        .count(count_s), .tick(tick_s), .tc(tc_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: count enabled cycles and step on every DIV-th.
    task automatic model_edge();
        int mx, lv;
        bit clr;
        mx = int'(max_val);
        lv = int'(load_val);
`ifdef PRESCALED_COUNTER_OVF_EN
        clr = ovf_clr;
`else
        clr = 1'b0;
`endif
        for (int s = 0; s < 2; s++) begin
            m_tick[s] = 1'b0;
            m_tc[s]   = 1'b0;
            if (rst) begin
                m_cnt[s] = 0;
                m_ph[s]  = 0;
                m_ovf[s] = 1'b0;
            end else if (load) begin
                m_cnt[s] = (lv < mx) ? lv : mx;
                m_ph[s]  = 0;
                if (clr) m_ovf[s] = 1'b0;
            end else begin
                if (en) m_ph[s] = m_ph[s] + 1;
                if (en && m_ph[s] == DIV) begin
                    m_ph[s]   = 0;
                    m_tick[s] = 1'b1;
                    if (up) begin
                        if (m_cnt[s] >= mx) begin
                            m_tc[s]  = 1'b1;
                            m_cnt[s] = (s == 1) ? mx : 0;
                        end else begin
                            m_cnt[s] = m_cnt[s] + 1;
                        end
                    end else if (m_cnt[s] > mx) begin
                        m_cnt[s] = mx;
                    end else if (m_cnt[s] == 0) begin
                        m_tc[s]  = 1'b1;
                        m_cnt[s] = (s == 1) ? 0 : mx;
                    end else begin
                        m_cnt[s] = m_cnt[s] - 1;
                    end
                end
                if (m_tc[s]) m_ovf[s] = 1'b1;
                else if (clr) m_ovf[s] = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("count_wrap", count_w, m_cnt[0]);
        check("tick_wrap",  tick_w,  m_tick[0]);
        check("tc_wrap",    tc_w,    m_tc[0]);
        check("count_sat",  count_s, m_cnt[1]);
        check("tick_sat",   tick_s,  m_tick[1]);
        check("tc_sat",     tc_s,    m_tc[1]);
`ifdef PRESCALED_COUNTER_OVF_EN
        check("ovf_wrap", ovf_w, m_ovf[0]);
        check("ovf_sat",  ovf_s, m_ovf[1]);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        load_val = '0; max_val = 8'd255;
`ifdef PRESCALED_COUNTER_OVF_EN
        ovf_clr = 1'b0;
`endif
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_ph[s] = 0; m_tick[s] = 0; m_tc[s] = 0; m_ovf[s] = 0;
        end
        run(2);
        check("reset_count", count_w, 0);
        check("reset_tick",  tick_w,  0);

        // Full 8-bit wrap: 256 steps land back on 0 with tc.
        rst = 1'b0; en = 1'b1;
        run(256 * DIV);
        check("t1_wrap_count", count_w, 0);
        check("t1_wrap_tc",    tc_w,    1);

        // Modulo 10 with an enable pause mid-prescale.
        rst = 1'b1; run(1); rst = 1'b0;
        max_val = 8'd9;
        run(22);
        en = 1'b0; run(5);
        en = 1'b1; run(26);

        // Saturating countdown from a loaded 3, then up against max 2.
        load_val = 8'd3; load = 1'b1; run(1); load = 1'b0;
        up = 1'b0; run(6 * DIV);
        check("t3_sat_floor", count_s, 0);
        up = 1'b1; max_val = 8'd2; run(3 * DIV);
        check("t3_sat_top", count_s, 2);

        // Load clamps to max mid-prescale and restarts the phase.
        rst = 1'b1; run(1); rst = 1'b0;
        max_val = 8'd100; up = 1'b1;
        run(2);
        load_val = 8'd200; load = 1'b1; run(1); load = 1'b0;
        check("t4_load_clamp", count_w, 100);
        check("t4_load_tick",  tick_w,  0);
        run(DIV - 1);
        check("t4_no_early_tick", tick_w, 0);
        run(1);
        check("t4_tick_at_4", tick_w, 1);
        check("t4_wrap_zero", count_w, 0);
        up = 1'b0; run(DIV);
        max_val = 8'd50; run(DIV);
        check("t4_lowered_max", count_w, 50);
        check("t4_lowered_tc",  tc_w,    0);

        // Load coincides with a step: load wins, no tick.
        for (int i = 0; i < DIV + 1 && m_ph[0] != DIV - 1; i++) cyc();
        load_val = 8'd7; load = 1'b1; run(1);
        check("t5_load_wins_count", count_w, 7);
        check("t5_load_wins_tick",  tick_w,  0);
        rst = 1'b1; run(1);
        check("t5_rst_over_load", count_w, 0);
        rst = 1'b0; load = 1'b0;

`ifdef PRESCALED_COUNTER_OVF_EN
        // Sticky overflow on the 1->0 wrap, cleared by ovf_clr except on a wrap tick.
        max_val = 8'd1; up = 1'b1; en = 1'b1;
        run(3 * DIV);
        check("t6_ovf_set", ovf_w, 1);
        ovf_clr = 1'b1; run(1); ovf_clr = 1'b0;
        check("t6_ovf_clr", ovf_w, 0);
        ovf_clr = 1'b1;
        for (int i = 0; i < 4 * DIV && !(m_tc[0]); i++) cyc();
        ovf_clr = 1'b0;
        check("t6_wait_wrap", tc_w, 1);
        check("t6_ovf_kept",  ovf_w, 1);
`endif

        // Randomised traffic: occasional loads, resets and max changes.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 5);
            en       = ($urandom_range(0, 99) < 80);
            up       = $urandom_range(0, 1);
            load_val = WIDTH'($urandom);
            if ($urandom_range(0, 99) < 5) max_val = WIDTH'($urandom_range(0, 20));
`ifdef PRESCALED_COUNTER_OVF_EN
            ovf_clr  = ($urandom_range(0, 99) < 10);
`endif
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
